// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped IO window at 0x30000
// (RX/TX byte FIFOs, free-running cycle counter with snapshot, stop flag).
// Ports: clk_in/rst_in; CPU bus mem_a, mem_dout, mem_wr, mem_din;
// io_buffer_full; rx_valid_in/rx_data_in/rx_ready_out;
// tx_valid_out/tx_data_out/tx_ready_in; stop_out.

module mem_io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CAP);
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is taken only when a slot frees this cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rp];

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready_out,
  output logic        tx_valid_out,
  output logic [7:0]  tx_data_out,
  input  logic        tx_ready_in,
  output logic        stop_out
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_NEAR = (TXW+1)'(TX_DEPTH - 1);

  logic                  io;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  ram_rd;
  logic                  io_rd;
  logic                  io_rd_rx;
  logic                  io_rd_cnt;
  logic                  io_wr_tx;
  logic                  io_wr_stop;
  logic                  unused_hi;

  assign io         = (mem_a[17:16] == 2'b11);
  assign io_off     = mem_a[15:0];
  assign ram_idx    = mem_a[ADDR_WIDTH-1:0];
  assign unused_hi  = ^mem_a[31:18];

  assign ram_we     = mem_wr & ~io;
  assign ram_rd     = ~mem_wr & ~io;
  assign io_rd      = ~mem_wr & io;
  assign io_rd_rx   = io_rd & (io_off == 16'h0000);
  assign io_rd_cnt  = io_rd & (io_off == 16'h0004);
  assign io_wr_tx   = mem_wr & io & (io_off == 16'h0000)
                    & (mem_dout != 8'h00);
  assign io_wr_stop = mem_wr & io & (io_off == 16'h0004);

  // RAM: no reset so it can map onto block memory.
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
    if (ram_rd) begin
      ram_q <= ram[ram_idx];
    end
  end

  logic [31:0] cycle_cnt;
  logic [31:0] snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
      stop_out  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (io_rd_cnt) begin
        snap <= cycle_cnt;
      end
      if (io_wr_stop) begin
        stop_out <= 1'b1;
      end
    end
  end

  logic         tx_push;
  logic [7:0]   tx_byte;
  logic         tx_pop;
  logic         tx_empty;
  logic         unused_tx_full;
  logic [TXW:0] tx_count;

  assign tx_push      = io_wr_tx | io_wr_stop;
  assign tx_byte      = io_wr_stop ? 8'h00 : mem_dout;
  assign tx_valid_out = ~tx_empty;
  assign tx_pop       = tx_valid_out & tx_ready_in;
  assign io_buffer_full = (tx_count >= TX_NEAR);

  mem_io_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_byte),
    .pop       (tx_pop),
    .head      (tx_data_out),
    .count     (tx_count),
    .empty     (tx_empty),
    .full      (unused_tx_full)
  );

  logic         rx_push;
  logic         rx_pop;
  logic         rx_empty;
  logic         rx_full;
  logic [7:0]   rx_head;
  logic [RXW:0] unused_rx_count;

  assign rx_ready_out = ~rx_full;
  assign rx_push      = rx_valid_in & rx_ready_out;
  // An empty FIFO is never popped, even if a byte lands this cycle.
  assign rx_pop       = io_rd_rx & ~rx_empty;

  mem_io_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_push),
    .push_data (rx_data_in),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (unused_rx_count),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  logic [7:0] io_rd_data;

  always_comb begin
    io_rd_data = 8'h00;
    unique case (io_off)
      16'h0000: io_rd_data = rx_empty ? 8'h00 : rx_head;
      16'h0004: io_rd_data = cycle_cnt[7:0];
      16'h0005: io_rd_data = snap[15:8];
      16'h0006: io_rd_data = snap[23:16];
      16'h0007: io_rd_data = snap[31:24];
      default:  io_rd_data = 8'h00;
    endcase
  end

  // Read data is split into a RAM register and an IO register; sel_ram
  // picks the one loaded by the last read. Both hold during writes.
  logic       sel_ram;
  logic [7:0] io_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram <= 1'b0;
      io_q    <= 8'h00;
    end else if (!mem_wr) begin
      sel_ram <= ~io;
      if (io) begin
        io_q <= io_rd_data;
      end
    end
  end

  assign mem_din = sel_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed stimulus with queued expectations
// checked by a separate monitor on read data and the TX stream.

module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid_in = 1'b0;
  logic [7:0]  rx_data_in = '0;
  logic        rx_ready_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in = 1'b0;
  logic        stop_out;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid_in    (rx_valid_in),
    .rx_data_in     (rx_data_in),
    .rx_ready_out   (rx_ready_out),
    .tx_valid_out   (tx_valid_out),
    .tx_data_out    (tx_data_out),
    .tx_ready_in    (tx_ready_in),
    .stop_out       (stop_out)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic       issue = 1'b0;
  logic       rd_vld;
  logic [31:0] cyc;
  logic [31:0] snap;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference cycle count and read-issue pipeline.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_vld <= 1'b0;
      cyc    <= '0;
    end else begin
      rd_vld <= issue;
      cyc    <= cyc + 32'd1;
    end
  end

  // Monitor: read data one cycle after issue, TX bytes on handshake.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (rd_vld) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=%0h required=none", mem_din);
        end else begin
          chk("mem_din", {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
        end
      end
      if (tx_valid_out && tx_ready_in) begin
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=none",
                   tx_data_out);
        end else begin
          chk("tx_data", {24'h0, tx_data_out}, {24'h0, tx_q.pop_front()});
        end
      end
    end
  end

  task automatic idle(input int n);
    mem_a = '0;
    mem_wr = 1'b0;
    mem_dout = '0;
    issue = 1'b0;
    rx_valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a;
    mem_wr = 1'b1;
    mem_dout = d;
    issue = 1'b0;
    rx_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    mem_a = a;
    mem_wr = 1'b0;
    issue = 1'b1;
    rx_valid_in = 1'b0;
    rd_q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  task automatic rxp(input logic [7:0] b);
    mem_a = '0;
    mem_wr = 1'b0;
    issue = 1'b0;
    rx_valid_in = 1'b1;
    rx_data_in = b;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    int n;
    idle(0);
    tx_ready_in = 1'b1;
    n = 0;
    while ((tx_q.size() != 0 || tx_valid_out) && n < 40) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("tx_drain_left", tx_q.size(), 0);
    chk("tx_drain_valid", {31'h0, tx_valid_out}, 0);
    tx_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    idle(0);
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_mem_din", {24'h0, mem_din}, 0);
    chk("rst_stop", {31'h0, stop_out}, 0);
    chk("rst_tx_valid", {31'h0, tx_valid_out}, 0);
    chk("rst_rx_ready", {31'h0, rx_ready_out}, 1);
    chk("rst_buf_full", {31'h0, io_buffer_full}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // RAM: write then read, hold during writes, high bits ignored
    wr(32'h0, 8'h00);
    wr(32'h10, 8'hA5);
    rd(32'h10, 8'hA5);
    wr(32'h20, 8'h3C);
    chk("mem_din_hold", {24'h0, mem_din}, 32'hA5);
    rd(32'hFFFC0010, 8'hA5);
    rd(32'h20, 8'h3C);
    wr(32'h10, 8'h5A);
    rd(32'h10, 8'h5A);
    idle(2);

    // TX: zero byte ignored
    tx_ready_in = 1'b0;
    tx_q.push_back(8'h41);
    tx_q.push_back(8'h42);
    wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h42);
    idle(1);
    chk("tx_head_valid", {31'h0, tx_valid_out}, 1);
    chk("tx_head_data", {24'h0, tx_data_out}, 32'h41);
    drain();

    // TX: nearly-full flag and drop on full
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_q.push_back(8'(8'h60 + i));
      wr(32'h30000, 8'(8'h60 + i));
      if (i == 6) chk("buf_full_at6", {31'h0, io_buffer_full}, 0);
      if (i == 7) chk("buf_full_at7", {31'h0, io_buffer_full}, 1);
    end
    idle(1);
    chk("buf_full_at9", {31'h0, io_buffer_full}, 1);
    drain();
    chk("buf_full_drained", {31'h0, io_buffer_full}, 0);

    // RX: empty read, push then read
    rd(32'h30000, 8'h00);
    rxp(8'h55);
    rd(32'h30000, 8'h55);
    rd(32'h30000, 8'h00);
    idle(1);

    // RX: read while empty in the same cycle as a push
    mem_a = 32'h30000;
    mem_wr = 1'b0;
    issue = 1'b1;
    rd_q.push_back(8'h00);
    rx_valid_in = 1'b1;
    rx_data_in = 8'h77;
    @(posedge clk_in);
    #1;
    rd(32'h30000, 8'h77);
    rd(32'h30000, 8'h00);
    idle(1);

    // RX: simultaneous push and pop
    rxp(8'h11);
    mem_a = 32'h30000;
    mem_wr = 1'b0;
    issue = 1'b1;
    rd_q.push_back(8'h11);
    rx_valid_in = 1'b1;
    rx_data_in = 8'h22;
    @(posedge clk_in);
    #1;
    rd(32'h30000, 8'h22);
    rd(32'h30000, 8'h00);
    idle(1);

    // RX: fill to full across pointer wrap, overflow refused
    for (int i = 0; i < 8; i++) rxp(8'(8'h80 + i));
    idle(0);
    chk("rx_full_ready", {31'h0, rx_ready_out}, 0);
    rxp(8'hEE);
    for (int i = 0; i < 8; i++) rd(32'h30000, 8'(8'h80 + i));
    rd(32'h30000, 8'h00);
    idle(1);
    chk("rx_empty_ready", {31'h0, rx_ready_out}, 1);

    // Unmapped IO addresses
    rd(32'h30008, 8'h00);
    rd(32'h30001, 8'h00);
    wr(32'h30001, 8'h5A);
    wr(32'h30008, 8'h33);
    idle(1);
    chk("unmapped_tx", {31'h0, tx_valid_out}, 0);
    chk("unmapped_stop", {31'h0, stop_out}, 0);

    // Cycle counter snapshot
    do_reset();
    idle(100);
    snap = cyc;
    rd(32'h30004, snap[7:0]);
    rd(32'h30005, snap[15:8]);
    rd(32'h30006, snap[23:16]);
    rd(32'h30007, snap[31:24]);
    idle(3);
    rd(32'h30005, snap[15:8]);
    idle(1);

    // Stop flag, then reset mid-stream
    rxp(8'h99);
    wr(32'h30004, 8'h00);
    idle(1);
    chk("stop_set", {31'h0, stop_out}, 1);
    chk("stop_tx_valid", {31'h0, tx_valid_out}, 1);
    chk("stop_tx_data", {24'h0, tx_data_out}, 0);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_stop", {31'h0, stop_out}, 0);
    chk("mid_rst_tx_valid", {31'h0, tx_valid_out}, 0);
    chk("mid_rst_rx_ready", {31'h0, rx_ready_out}, 1);
    chk("mid_rst_mem_din", {24'h0, mem_din}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rd(32'h30000, 8'h00);
    rd(32'h10, 8'h5A);
    rd(32'h30005, 8'h00);
    idle(3);
    chk("post_rst_tx_valid", {31'h0, tx_valid_out}, 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the RAM size to 2^ADDR_WIDTH bytes.
REQ-002 Parameter TX_DEPTH, default 8 (power of two, >=4), SHALL set the output byte FIFO depth.
REQ-003 Parameter RX_DEPTH, default 8 (power of two, >=2), SHALL set the input byte FIFO depth.
REQ-004 clk_in  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 mem_a  input  32  byte address from the CPU; only bits [17:0] are decoded.
REQ-007 mem_dout  input  8  CPU write data.
REQ-008 mem_wr  input  1  1 = write, 0 = read.
REQ-009 mem_din  output  8  registered read data to the CPU.
REQ-010 io_buffer_full  output  1  TX FIFO nearly full; the CPU must not issue output writes while high.
REQ-011 rx_valid_in / rx_data_in  input  1 / 8  host input byte stream.
REQ-012 rx_ready_out  output  1  RX FIFO can accept a byte.
REQ-013 tx_valid_out / tx_data_out  output  1 / 8  output byte stream (UART side).
REQ-014 tx_ready_in  input  1  sink accepts tx_data_out.
REQ-015 stop_out  output  1  sticky program-stop flag.

Function
REQ-016 Decode: io = (mem_a[17:16]==2'b11); otherwise a RAM access at index mem_a[ADDR_WIDTH-1:0].
REQ-017 RAM write (mem_wr=1, !io) SHALL store mem_dout at the edge; 1-cycle, no acknowledge.
REQ-018 Read (mem_wr=0) SHALL update mem_din at the next edge (1-cycle latency); in write cycles mem_din SHALL hold its value.
REQ-019 RAM read-after-write to the same address in consecutive cycles SHALL return the new byte.
REQ-020 IO read 0x30000 SHALL return the RX FIFO head and pop it; on empty, SHALL return 0x00 with no pop.
REQ-021 IO read 0x30004 SHALL return cycle counter bits [7:0] and latch the full 32-bit counter into a snapshot; reads of 0x30005/6/7 SHALL return snapshot bytes 1/2/3.
REQ-022 Cycle counter: 32 bits, 0 at reset, +1 every cycle, wraps 0xFFFFFFFF->0.
REQ-023 IO write 0x30000 with a nonzero byte SHALL push it to the TX FIFO; a 0x00 byte SHALL be ignored.
REQ-024 IO write 0x30004 SHALL set stop_out=1 (held until reset) and push 0x00 to the TX FIFO.
REQ-025 Any other IO address: reads return 0x00, writes are ignored.
REQ-026 TX FIFO: tx_valid_out = !empty, tx_data_out = head; pop when tx_valid_out & tx_ready_in.
REQ-027 TX push on full SHALL be accepted only if a pop occurs in the same cycle, else dropped; count never exceeds TX_DEPTH.
REQ-028 io_buffer_full SHALL be combinationally 1 when TX count >= TX_DEPTH-1.
REQ-029 RX FIFO: rx_ready_out = !full; push when rx_valid_in & rx_ready_out; a simultaneous push and pop SHALL both take effect.
REQ-030 An IO read of 0x30000 when RX is empty in the same cycle as a push SHALL return 0x00; the pushed byte remains queued.
REQ-031 FIFO pointers SHALL wrap modulo depth; byte order SHALL be preserved.

Reset
REQ-032 On rst_in=0, immediately: mem_din=0x00, stop_out=0, counter=0, snapshot=0, both FIFOs empty (tx_valid_out=0, rx_ready_out=1, io_buffer_full=0).
REQ-033 RAM contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-stream SHALL discard queued FIFO bytes; operation resumes on the first edge after deassertion.

Verification
REQ-035 Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address.
REQ-036 tx_ready_in=0; write 0x41, 0x00, 0x42 to 0x30000 -> TX holds 0x41,0x42 only; raise tx_ready_in -> 0x41 then 0x42 emitted.
REQ-037 tx_ready_in=0; write 7 nonzero bytes (TX_DEPTH=8) -> io_buffer_full=1 after the 7th; 8th accepted, 9th dropped.
REQ-038 Run 100 cycles after reset, read 0x30004..0x30007 on consecutive cycles -> the four bytes form the counter value at the 0x30004 read.
REQ-039 RX empty, read 0x30000 -> 0x00; push 0x55 via rx_valid_in, read again -> 0x55, RX empty.
REQ-040 Write to 0x30004 -> stop_out=1 and 0x00 appears on tx_data_out; assert rst_in=0 -> stop_out=0 and tx_valid_out=0 at once.
